rob_multiport: RTL

//  Parametrised reorder buffer with NUM_WB writeback channels and a decode allocation handshake.

---
 rtl/rob_multiport_if.sv | 48 ++++
 rtl/rob_multiport.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport_if.sv
// Bus bundle for rob_multiport: decode allocation handshake, NUM_WB writeback
// channels (flattened, channel i at [i*W +: W]), commit/exception outputs and
// the external flush. The master side is decode/execute; the slave is the ROB.
interface rob_multiport_if #(
  parameter int ARCH_BITS    = 32,
  parameter int REG_IDX_BITS = 5,
  parameter int ROB_IDX_BITS = 4,
  parameter int NUM_WB       = 3
);
  // control
  logic                           flush;
  // allocation handshake
  logic                           alloc_req;
  logic                           alloc_ready;
  logic [ROB_IDX_BITS-1:0]        alloc_idx;
  // writeback channels
  logic [NUM_WB-1:0]              wb_valid;
  logic [NUM_WB*ROB_IDX_BITS-1:0] wb_idx;
  logic [NUM_WB-1:0]              wb_except;
  logic [NUM_WB*ARCH_BITS-1:0]    wb_pc;
  logic [NUM_WB*ARCH_BITS-1:0]    wb_addr;
  logic [NUM_WB*ARCH_BITS-1:0]    wb_data;
  logic [NUM_WB*REG_IDX_BITS-1:0] wb_dst;
  logic [NUM_WB-1:0]              wb_we;
  // commit / exception / status
  logic                           reg_we;
  logic [REG_IDX_BITS-1:0]        reg_dst;
  logic [ARCH_BITS-1:0]           reg_data;
  logic                           except_valid;
  logic [ARCH_BITS-1:0]           except_addr;
  logic [ARCH_BITS-1:0]           except_pc;
  logic                           wb_err;
  logic [ROB_IDX_BITS:0]          count;

  modport master (
    output flush, alloc_req,
    output wb_valid, wb_idx, wb_except, wb_pc, wb_addr, wb_data, wb_dst, wb_we,
    input  alloc_ready, alloc_idx,
    input  reg_we, reg_dst, reg_data, except_valid, except_addr, except_pc, wb_err, count
  );

  modport slave (
    input  flush, alloc_req,
    input  wb_valid, wb_idx, wb_except, wb_pc, wb_addr, wb_data, wb_dst, wb_we,
    output alloc_ready, alloc_idx,
    output reg_we, reg_dst, reg_data, except_valid, except_addr, except_pc, wb_err, count
  );
endinterface

// File: rtl/rob_multiport.sv
// Reorder buffer with NUM_WB out-of-order writeback channels.
// Decode allocates at the tail, execution units mark entries done, and the
// head retires in order, one per cycle. A faulting head raises a precise
// exception and wipes the buffer; an external flush wipes it as well.
module rob_multiport #(
  parameter int ARCH_BITS    = 32,
  parameter int REG_IDX_BITS = 5,
  parameter int ROB_IDX_BITS = 4,
  parameter int NUM_WB       = 3
) (
  input logic            clk,
  input logic            rst,     // asynchronous, active-low
  rob_multiport_if.slave rob
);
  localparam int ROB_SLOTS = int'(32'd1 << ROB_IDX_BITS);
  localparam int CNT_W     = ROB_IDX_BITS + 1;
  localparam logic [CNT_W-1:0]        SLOTS_CNT = CNT_W'(ROB_SLOTS);
  localparam logic [ROB_IDX_BITS-1:0] IDX_ONE   = ROB_IDX_BITS'(1);

  // pointers and occupancy
  logic [ROB_IDX_BITS-1:0] head_q, head_d;
  logic [ROB_IDX_BITS-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // per-entry state
  logic [ROB_SLOTS-1:0]    alloc_q, alloc_d;
  logic [ROB_SLOTS-1:0]    done_q, done_d;
  logic [ROB_SLOTS-1:0]    exc_q, exc_d;
  logic [ROB_SLOTS-1:0]    we_q, we_d;
  logic [ARCH_BITS-1:0]    pc_q   [ROB_SLOTS];
  logic [ARCH_BITS-1:0]    pc_d   [ROB_SLOTS];
  logic [ARCH_BITS-1:0]    addr_q [ROB_SLOTS];
  logic [ARCH_BITS-1:0]    addr_d [ROB_SLOTS];
  logic [ARCH_BITS-1:0]    data_q [ROB_SLOTS];
  logic [ARCH_BITS-1:0]    data_d [ROB_SLOTS];
  logic [REG_IDX_BITS-1:0] dst_q  [ROB_SLOTS];
  logic [REG_IDX_BITS-1:0] dst_d  [ROB_SLOTS];

  // output registers
  logic                    reg_we_q, reg_we_d;
  logic [REG_IDX_BITS-1:0] reg_dst_q, reg_dst_d;
  logic [ARCH_BITS-1:0]    reg_data_q, reg_data_d;
  logic                    except_valid_q, except_valid_d;
  logic [ARCH_BITS-1:0]    except_addr_q, except_addr_d;
  logic [ARCH_BITS-1:0]    except_pc_q, except_pc_d;
  logic                    wb_err_q, wb_err_d;

  // decode of the registered head entry
  logic                    alloc_ready_s;
  logic                    alloc_fire_s;
  logic                    head_ready_s;
  logic                    commit_s;
  logic                    except_s;
  logic                    clear_s;
  logic [ROB_IDX_BITS-1:0] wb_slot_s;

  // A slot is free only by the registered count; a same-cycle commit does not help.
  assign alloc_ready_s = (count_q < SLOTS_CNT);
  assign alloc_fire_s  = rob.alloc_req && alloc_ready_s;
  assign head_ready_s  = (count_q != {CNT_W{1'b0}}) && done_q[head_q];
  assign commit_s      = head_ready_s && !exc_q[head_q];
  assign except_s      = head_ready_s && exc_q[head_q];
  assign clear_s       = rob.flush || except_s;

  // Next-state: clear on flush/exception, else allocate, apply writebacks, retire head.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    alloc_d        = alloc_q;
    done_d         = done_q;
    exc_d          = exc_q;
    we_d           = we_q;
    pc_d           = pc_q;
    addr_d         = addr_q;
    data_d         = data_q;
    dst_d          = dst_q;
    reg_we_d       = 1'b0;
    reg_dst_d      = reg_dst_q;
    reg_data_d     = reg_data_q;
    except_valid_d = 1'b0;
    except_addr_d  = except_addr_q;
    except_pc_d    = except_pc_q;
    wb_err_d       = 1'b0;
    wb_slot_s      = {ROB_IDX_BITS{1'b0}};

    if (clear_s) begin
      // Whole-buffer clear; same-cycle alloc and writebacks are discarded.
      head_d  = {ROB_IDX_BITS{1'b0}};
      tail_d  = {ROB_IDX_BITS{1'b0}};
      count_d = {CNT_W{1'b0}};
      alloc_d = {ROB_SLOTS{1'b0}};
      done_d  = {ROB_SLOTS{1'b0}};
      exc_d   = {ROB_SLOTS{1'b0}};
      if (except_s) begin
        except_valid_d = 1'b1;
        except_addr_d  = addr_q[head_q];
        except_pc_d    = pc_q[head_q];
      end else begin
        except_valid_d = 1'b0;
      end
    end else begin
      if (alloc_fire_s) begin
        alloc_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + IDX_ONE;
      end else begin
        tail_d = tail_q;
      end

      // Ascending channel order so the highest channel wins a same-index collision.
      for (int i = 0; i < NUM_WB; i++) begin
        wb_slot_s = rob.wb_idx[i*ROB_IDX_BITS +: ROB_IDX_BITS];
        if (rob.wb_valid[i]) begin
          if (alloc_q[wb_slot_s]) begin
            done_d[wb_slot_s] = 1'b1;
            exc_d[wb_slot_s]  = rob.wb_except[i];
            we_d[wb_slot_s]   = rob.wb_we[i];
            pc_d[wb_slot_s]   = rob.wb_pc[i*ARCH_BITS +: ARCH_BITS];
            addr_d[wb_slot_s] = rob.wb_addr[i*ARCH_BITS +: ARCH_BITS];
            data_d[wb_slot_s] = rob.wb_data[i*ARCH_BITS +: ARCH_BITS];
            dst_d[wb_slot_s]  = rob.wb_dst[i*REG_IDX_BITS +: REG_IDX_BITS];
          end else begin
            wb_err_d = 1'b1;
          end
        end else begin
          wb_err_d = wb_err_d;
        end
      end

      // Retirement reads the registered entry, so a writeback this cycle is not seen yet.
      if (commit_s) begin
        reg_we_d        = we_q[head_q];
        reg_dst_d       = dst_q[head_q];
        reg_data_d      = data_q[head_q];
        alloc_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + IDX_ONE;
      end else begin
        reg_we_d = 1'b0;
      end

      count_d = count_q + CNT_W'(alloc_fire_s) - CNT_W'(commit_s);
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q         <= {ROB_IDX_BITS{1'b0}};
      tail_q         <= {ROB_IDX_BITS{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      alloc_q        <= {ROB_SLOTS{1'b0}};
      done_q         <= {ROB_SLOTS{1'b0}};
      exc_q          <= {ROB_SLOTS{1'b0}};
      we_q           <= {ROB_SLOTS{1'b0}};
      for (int k = 0; k < ROB_SLOTS; k++) begin
        pc_q[k]   <= {ARCH_BITS{1'b0}};
        addr_q[k] <= {ARCH_BITS{1'b0}};
        data_q[k] <= {ARCH_BITS{1'b0}};
        dst_q[k]  <= {REG_IDX_BITS{1'b0}};
      end
      reg_we_q       <= 1'b0;
      reg_dst_q      <= {REG_IDX_BITS{1'b0}};
      reg_data_q     <= {ARCH_BITS{1'b0}};
      except_valid_q <= 1'b0;
      except_addr_q  <= {ARCH_BITS{1'b0}};
      except_pc_q    <= {ARCH_BITS{1'b0}};
      wb_err_q       <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      alloc_q        <= alloc_d;
      done_q         <= done_d;
      exc_q          <= exc_d;
      we_q           <= we_d;
      pc_q           <= pc_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      dst_q          <= dst_d;
      reg_we_q       <= reg_we_d;
      reg_dst_q      <= reg_dst_d;
      reg_data_q     <= reg_data_d;
      except_valid_q <= except_valid_d;
      except_addr_q  <= except_addr_d;
      except_pc_q    <= except_pc_d;
      wb_err_q       <= wb_err_d;
    end
  end

  assign rob.alloc_ready  = alloc_ready_s;
  assign rob.alloc_idx    = tail_q;
  assign rob.reg_we       = reg_we_q;
  assign rob.reg_dst      = reg_dst_q;
  assign rob.reg_data     = reg_data_q;
  assign rob.except_valid = except_valid_q;
  assign rob.except_addr  = except_addr_q;
  assign rob.except_pc    = except_pc_q;
  assign rob.wb_err       = wb_err_q;
  assign rob.count        = count_q;
endmodule
